// File: rtl/nn_pkg.sv
// Shared constants and FSM state type for the writable weight store.
package nn_pkg;
  localparam int N_INPUTS  = 784;
  localparam int N_NEURONS = 10;
  localparam int DEPTH     = N_INPUTS * N_NEURONS;
  localparam int ADDR_W    = 13;
  localparam int DATA_W    = 8;
  localparam int CSUM_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/weight_ram.sv
// DEPTH x DATA_W synchronous RAM: one write port, one registered read port, read-before-write.
module weight_ram
  import nn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  logic              w_rd_in_range;

  assign w_rd_in_range = (i_rd_addr < ADDR_W'(DEPTH));

  // Contents survive reset; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (w_rd_in_range) begin
      r_rd_data <= r_mem[i_rd_addr];
    end else begin
      r_rd_data <= '0;
    end
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/weight_loader.sv
// Streams quantised weights into the weight RAM and reports progress and a running checksum.
module weight_loader
  import nn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] load_count,
  output logic [CSUM_W-1:0] checksum
);
  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_load_count;
  logic [CSUM_W-1:0] r_checksum;
  logic              w_xfer;
  logic              w_last;
  logic              w_restart;

  assign w_xfer    = s_valid && (r_state == LOAD);
  assign w_last    = w_xfer && (r_wr_addr == ADDR_W'(DEPTH - 1));
  assign w_restart = start && (r_state != LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_next = LOAD;
      LOAD:    if (w_last) w_state_next = DONE;
      DONE:    if (start)  w_state_next = LOAD;
      default: w_state_next = IDLE;
    endcase
  end

  // The address holds at DEPTH-1 on the final write; DONE blocks further writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr    <= '0;
      r_load_count <= '0;
      r_checksum   <= '0;
    end else if (w_restart) begin
      r_wr_addr    <= '0;
      r_load_count <= '0;
      r_checksum   <= '0;
    end else if (w_xfer) begin
      if (!w_last) begin
        r_wr_addr <= r_wr_addr + 1'b1;
      end
      r_load_count <= r_load_count + 1'b1;
      r_checksum   <= r_checksum + CSUM_W'(s_data);
    end
  end

  weight_ram u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_xfer),
    .i_wr_addr (r_wr_addr),
    .i_wr_data (s_data),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data)
  );

  assign s_ready    = (r_state == LOAD);
  assign busy       = (r_state == LOAD);
  assign done       = (r_state == DONE);
  assign load_count = r_load_count;
  assign checksum   = r_checksum;
endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: full loads, backpressure, ignored start, collision, reset, reload.
module tb_weight_loader;
  import nn_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] load_count;
  logic [CSUM_W-1:0] checksum;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int addr;
    int exp_data;
  } rd_vec_t;

  rd_vec_t rd_tab[6];

  weight_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .load_count (load_count),
    .checksum   (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end else begin
      $display("[TB] ok   %s = 0x%0h", name, actual);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, int'(s_ready), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_load_count"}, int'(load_count), 0);
    check({tag, "_checksum"}, int'(checksum), 0);
    check({tag, "_rd_data"}, int'(rd_data), 0);
  endtask

  task automatic readback(input string tag);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rd_addr = ADDR_W'(rd_tab[i].addr);
      @(negedge clk);
      check($sformatf("%s_rd[%0d]", tag, rd_tab[i].addr), int'(rd_data), rd_tab[i].exp_data);
    end
  endtask

  // gap: drop s_valid every third cycle; ones: stream 0x01; restart_at: pulse start with that byte.
  task automatic do_load(input string tag, input bit gap, input bit ones,
                         input int restart_at, input int exp_ck);
    int idx;
    int cyc;
    bit busy_ok;
    bit v;
    @(negedge clk);
    start   = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_rise"}, int'(busy), 1);
    idx = 0;
    cyc = 0;
    busy_ok = 1'b1;
    while (idx < DEPTH && cyc < 20000) begin
      v       = !(gap && (cyc % 3 == 2));
      s_valid = v;
      s_data  = ones ? 8'h01 : DATA_W'(idx);
      start   = (idx == restart_at) && v;
      if (!busy || !s_ready) busy_ok = 1'b0;
      @(posedge clk);
      if (v) idx++;
      cyc++;
      @(negedge clk);
      start = 1'b0;
      if (idx == 600) check({tag, "_count_600"}, int'(load_count), 600);
    end
    s_valid = 1'b0;
    check({tag, "_bytes_sent"}, idx, DEPTH);
    check({tag, "_busy_held"}, int'(busy_ok), 1);
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_busy_low"}, int'(busy), 0);
    check({tag, "_load_count"}, int'(load_count), DEPTH);
    check({tag, "_checksum"}, int'(checksum), exp_ck);
  endtask

  initial begin
    rd_tab[0] = '{0,    8'h00};
    rd_tab[1] = '{10,   8'h0A};
    rd_tab[2] = '{784,  8'h10};
    rd_tab[3] = '{7839, 8'h9F};
    rd_tab[4] = '{7840, 8'h00};
    rd_tab[5] = '{8191, 8'h00};

    rst_n   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    rd_addr = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_s_ready", int'(s_ready), 0);

    do_load("full", 1'b0, 1'b0, -1, 16'h22B0);
    readback("full");

    do_load("bp", 1'b1, 1'b0, -1, 16'h22B0);
    readback("bp");

    do_load("ign", 1'b0, 1'b0, 500, 16'h22B0);
    s_valid = 1'b1;
    s_data  = 8'hFF;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0 || k == 19) check($sformatf("done_s_ready_%0d", k), int'(s_ready), 0);
    end
    s_valid = 1'b0;
    check("extra_load_count", int'(load_count), DEPTH);
    check("extra_checksum", int'(checksum), 16'h22B0);
    rd_addr = 13'd7839;
    @(negedge clk);
    check("extra_rd_7839", int'(rd_data), 8'h9F);

    // Collision at address 20, then reset after 100 bytes.
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    rd_addr = 13'd20;
    for (int idx = 0; idx < 100; idx++) begin
      s_valid = 1'b1;
      s_data  = (idx == 20) ? 8'hAA : DATA_W'(idx);
      @(negedge clk);
      if (idx == 20) check("collide_old", int'(rd_data), 8'h14);
      if (idx == 21) check("collide_new", int'(rd_data), 8'hAA);
    end
    s_valid = 1'b0;
    check("mid_load_count", int'(load_count), 100);
    check("mid_checksum", int'(checksum), 16'h13EC);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h55;
    repeat (5) @(negedge clk);
    check("post_rst_no_start_busy", int'(busy), 0);
    check("post_rst_no_start_count", int'(load_count), 0);
    s_valid = 1'b0;

    do_load("restart", 1'b0, 1'b0, -1, 16'h22B0);
    rd_addr = 13'd20;
    @(negedge clk);
    check("restart_rd_20", int'(rd_data), 8'h14);

    do_load("reload", 1'b0, 1'b1, -1, 16'h1EA0);
    rd_addr = 13'd784;
    @(negedge clk);
    check("reload_rd_784", int'(rd_data), 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/weight_loader.md
# weight_loader

Writable replacement for the weight ROM that the MAC datapath reads from. It accepts a byte stream of quantised weights over a valid/ready handshake and writes them sequentially into an internal DEPTH×8 RAM (row-major: neuron n, input i at address n·N_INPUTS+i). It serves reads on the same addr/data contract the datapath already uses, with one cycle of registered latency. It also reports progress, completion and a running checksum, so software can confirm the load matches weights.mem.

## Interface
- N_INPUTS, 784, inputs per neuron
- N_NEURONS, 10, neurons in the layer
- DEPTH, N_INPUTS*N_NEURONS (7840), RAM entries
- ADDR_W, 13, address width; must satisfy 2^ADDR_W ≥ DEPTH
- DATA_W, 8, weight width (signed Q-format, stored opaquely)

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE
- s_valid  in  1  stream byte valid
- s_data  in  DATA_W  stream byte
- s_ready  out  1  loader accepts a byte this cycle
- rd_addr  in  ADDR_W  read address from the datapath
- rd_data  out  DATA_W  registered read data
- busy  out  1  high in LOAD
- done  out  1  high in DONE; level signal
- load_count  out  ADDR_W  bytes written in the current or last load
- checksum  out  16  modulo-2^16 sum of the bytes written, treated as unsigned

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE → LOAD on start.
  - Clears wr_addr, load_count and checksum in the same edge.
- LOAD behaviour:
  - s_ready = 1.
  - A transfer occurs when s_valid && s_ready.
  - On a transfer: mem[wr_addr] ← s_data, wr_addr++, load_count++, checksum += s_data.
- LOAD → DONE on the transfer that writes address DEPTH-1.
  - load_count = DEPTH after that edge.
- DONE behaviour:
  - s_ready = 0; extra stream bytes are not accepted.
  - start re-enters LOAD and clears the counters as above.
- start during LOAD is ignored. There is no abort; only rst_n aborts.
- s_ready depends only on state. There is no combinational path from s_valid.
- Reads:
  - rd_data ← mem[rd_addr] every cycle, in all states.
  - rd_addr ≥ DEPTH returns 0x00.
- Read/write collision at the same address in the same cycle: read-before-write, i.e. rd_data returns the old contents.
- Arithmetic:
  - checksum wraps modulo 2^16.
  - wr_addr never exceeds DEPTH-1. There is no wrap; DONE stops writes.

## Timing
- Reset values: state = IDLE, s_ready = 0, busy = 0, done = 0, load_count = 0, checksum = 0, rd_data = 0.
- RAM contents are not cleared by reset and are undefined until first written.
- Read latency: rd_data valid 1 cycle after rd_addr is sampled.
- Write throughput: 1 byte per cycle while s_valid is held. A full load takes DEPTH cycles plus 1 start cycle.
- busy rises the cycle after start. done rises the cycle after the final transfer.
- Backpressure gaps (s_valid low) stall the counters with no loss.
- Reset mid-load: all registers return to reset values immediately. Partially written RAM keeps its data. A new start is required.
- start coinciding with the final transfer (in LOAD): ignored; the FSM enters DONE.

## Structure
- Shared package `nn_pkg`:
  - N_INPUTS, N_NEURONS, DEPTH, ADDR_W, DATA_W
  - FSM state enum (IDLE/LOAD/DONE)
  - checksum width
- One sub-module, `weight_ram`: single-port-write / single-port-read synchronous RAM, read-before-write, inferable as block RAM.
- weight_loader holds the FSM, counters and checksum.

## Test plan
- **Full load:** pulse start, then stream data = addr[7:0] for 7840 cycles without gaps.
  - Required: done = 1, load_count = 7840, checksum = 0x22B0.
  - Readback: rd_addr 0/10/784/7839 → rd_data 0x00/0x0A/0x10/0x9F one cycle later.
- **Backpressure:** same stream with s_valid low every third cycle.
  - Required: identical checksum and readback; busy stays high throughout.
- **Ignored start and extra bytes:** pulse start at byte 500; after DONE, hold s_valid with 0xFF.
  - Required: load_count stays on course (no restart); s_ready = 0 in DONE; mem[7839] stays 0x9F.
- **Out of range and collision:**
  - rd_addr = 7840 → 0x00.
  - During LOAD, rd_addr = wr_addr = 20 with old content 0x14 and new byte 0xAA → rd_data = 0x14; next read → 0xAA.
- **Reset mid-load:** assert rst_n low after 100 bytes.
  - Required: all outputs return to reset values, state = IDLE.
  - Restart and full load → checksum 0x22B0.
- **Reload from DONE:** start again with data = 0x01 for all bytes.
  - Required: checksum = 7840 = 0x1EA0, load_count = 7840, rd_addr 784 → 0x01.
